// File: rtl/nand_pkg.sv
// Shared NAND byte-interface definitions: responder states, command opcodes and
// the address-cycle sequence also used by the NFC controller.
package nand_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    BUSY_R,
    READ_OUT,
    PROG_DATA,
    BUSY_P
  } state_t;

  typedef enum logic [1:0] {
    COL,
    ROW1,
    ROW2
  } addr_cyc_t;

  localparam logic [7:0] CMD_READ0   = 8'h00;
  localparam logic [7:0] CMD_READ1   = 8'h01;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

endpackage

// File: rtl/nand_busy_timer.sv
// Loadable busy down-counter; expire is high during the final busy cycle so the
// owner can leave its busy state on the same edge that busy drops.
module nand_busy_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - W'(1);
      if (cnt == W'(1)) busy <= 1'b0;
    end
  end

  assign expire = busy && (cnt == W'(1));

endmodule

// File: rtl/nand_flash_resp.sv
// Behavioural NAND-flash device: decodes read/program/reset sequences on the
// CLE/ALE/WEN/REN byte bus, serves page data and reports ready/busy on F_RB.
module nand_flash_resp
  import nand_pkg::*;
#(
  parameter int COL_W  = 9,
  parameter int ROW_W  = 9,
  parameter int T_R    = 8,
  parameter int T_PROG = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB,
  output logic [2:0] dbg_state
);

  localparam int AW   = ROW_W + COL_W;
  localparam int PAGE = 1 << COL_W;
  localparam int TW   = 16;

  logic [7:0]       mem  [0:(1<<AW)-1];
  logic [7:0]       pbuf [0:PAGE-1];
  logic [PAGE-1:0]  mask;
  state_t           state;
  addr_cyc_t        addr_cnt;
  logic             prog_mode;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [7:0] din;
  logic       wr_cmd, wr_addr, wr_data, rd_cyc, is_reset, commit, load_r, pbuf_we;
  logic       t_busy, t_expire;

  assign din      = F_IO;
  assign wr_cmd   = !F_WEN && F_CLE && !F_ALE;
  assign wr_addr  = !F_WEN && F_ALE && !F_CLE;
  assign wr_data  = !F_WEN && !F_CLE && !F_ALE;
  assign rd_cyc   = !F_REN && F_WEN && (state == READ_OUT);
  assign is_reset = wr_cmd && (din == CMD_RESET);
  assign commit   = wr_cmd && (state == PROG_DATA) && (din == CMD_CONFIRM);
  assign load_r   = wr_addr && (state == ADDR) && (addr_cnt == ROW2) && !prog_mode;
  assign pbuf_we  = wr_data && (state == PROG_DATA);

  nand_busy_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_r || commit),
    .clear    (is_reset),
    .load_val (commit ? TW'(T_PROG) : TW'(T_R)),
    .busy     (t_busy),
    .expire   (t_expire)
  );

  assign F_RB      = !t_busy;
  assign dbg_state = state;

  // Never drive while the controller holds a write strobe, so the bus cannot fight.
  assign F_IO = (state == READ_OUT && !F_REN && F_WEN) ? mem[{row, col}] : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_cnt  <= COL;
      prog_mode <= 1'b0;
      col       <= '0;
      row       <= '0;
      mask      <= '0;
    end else if (is_reset) begin
      state    <= IDLE;
      addr_cnt <= COL;
      col      <= '0;
      row      <= '0;
      mask     <= '0;
    end else if (state == BUSY_R || state == BUSY_P) begin
      if (t_expire) state <= (state == BUSY_R) ? READ_OUT : IDLE;
    end else if (wr_cmd) begin
      if (commit) begin
        state <= BUSY_P;
        mask  <= '0;
      end else if (din == CMD_READ0 || din == CMD_READ1) begin
        state            <= ADDR;
        prog_mode        <= 1'b0;
        addr_cnt         <= COL;
        col[COL_W-1]     <= din[0];
      end else if (din == CMD_PROG) begin
        state        <= ADDR;
        prog_mode    <= 1'b1;
        addr_cnt     <= COL;
        mask         <= '0;
        col[COL_W-1] <= 1'b0;
      end else begin
        state <= IDLE;
      end
    end else if (wr_addr && state == ADDR) begin
      case (addr_cnt)
        COL: begin
          col[7:0] <= din;
          addr_cnt <= ROW1;
        end
        ROW1: begin
          row[7:0] <= din;
          addr_cnt <= ROW2;
        end
        default: begin
          row[ROW_W-1] <= din[0];
          addr_cnt     <= COL;
          state        <= prog_mode ? PROG_DATA : BUSY_R;
        end
      endcase
    end else if (pbuf_we) begin
      mask[col] <= 1'b1;
      col       <= col + COL_W'(1);
    end else if (rd_cyc) begin
      col <= col + COL_W'(1);
    end
  end

  // Program buffer and array hold no reset: array contents survive rst.
  always_ff @(posedge clk) begin
    if (pbuf_we) pbuf[col] <= din;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < PAGE; i++) begin
        if (mask[i]) mem[{row, COL_W'(i)}] <= pbuf[i];
      end
    end
  end

endmodule

// File: tb/tb_nand_flash_resp.sv
// Self-checking bench for nand_flash_resp against a page/byte reference model.
module tb_nand_flash_resp;

  localparam int T_R    = 8;
  localparam int T_PROG = 16;
  localparam int PAGE   = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       cle, ale, wen, ren;
  logic [7:0] io_drv;
  logic       io_en;
  wire  [7:0] F_IO;
  wire        rb;
  wire  [2:0] dbg_state;

  assign F_IO = io_en ? io_drv : 8'hzz;

  nand_flash_resp #(.COL_W(9), .ROW_W(9), .T_R(T_R), .T_PROG(T_PROG)) dut (
    .clk       (clk),
    .rst       (rst),
    .F_IO      (F_IO),
    .F_CLE     (cle),
    .F_ALE     (ale),
    .F_WEN     (wen),
    .F_REN     (ren),
    .F_RB      (rb),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0] model_mem [int];
  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic write_cyc(input logic c, input logic a, input logic [7:0] d);
    @(negedge clk);
    cle = c; ale = a; wen = 1'b0; ren = 1'b1; io_en = 1'b1; io_drv = d;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    cle = 1'b0; ale = 1'b0; wen = 1'b1; ren = 1'b1; io_en = 1'b0;
  endtask

  task automatic send_addr(input int c, input int r);
    logic [8:0] cv, rv;
    cv = 9'(c);
    rv = 9'(r);
    write_cyc(1'b0, 1'b1, cv[7:0]);
    write_cyc(1'b0, 1'b1, rv[7:0]);
    write_cyc(1'b0, 1'b1, {7'($urandom), rv[8]});
  endtask

  // Counts low F_RB cycles sampled 1ns after each falling edge; bounded.
  task automatic measure_busy(output int cyc);
    cyc = 0;
    #1;
    while (rb === 1'b0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic read_byte(output logic [7:0] d);
    @(negedge clk);
    cle = 1'b0; ale = 1'b0; wen = 1'b1; ren = 1'b0; io_en = 1'b0;
    #1 d = F_IO;
  endtask

  task automatic read_seq(input int r, input int c, output int cyc);
    logic [8:0] cv;
    cv = 9'(c);
    write_cyc(1'b1, 1'b0, cv[8] ? 8'h01 : 8'h00);
    send_addr(c, r);
    idle_bus();
    measure_busy(cyc);
  endtask

  task automatic program_seq(input int r, input int c, input logic [7:0] data[$], output int cyc);
    write_cyc(1'b1, 1'b0, 8'h80);
    send_addr(c, r);
    foreach (data[k]) write_cyc(1'b0, 1'b0, data[k]);
    write_cyc(1'b1, 1'b0, 8'h10);
    idle_bus();
    foreach (data[k]) model_mem[r * PAGE + ((c + k) % PAGE)] = data[k];
    measure_busy(cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0; cle = 0; ale = 0; wen = 1; ren = 1; io_en = 0; io_drv = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rb !== 1'b1) begin n_fail++; $display("FAIL reset_rb: got %b want 1", rb); end
    @(negedge clk) rst = 1'b1;
    #1;
    n_checks++;
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    io_en = 1'b1; io_drv = 8'h5A;
    #1;
    n_checks++;
    if (F_IO !== 8'h5A) begin n_fail++; $display("FAIL idle_bus_release: got %h want 5a", F_IO); end
    for (int k = 0; k < 3; k++) write_cyc(1'b0, 1'b0, 8'($urandom));
    write_cyc(1'b0, 1'b1, 8'h12);
    write_cyc(1'b1, 1'b1, 8'h80);
    write_cyc(1'b1, 1'b0, 8'h10);
    idle_bus();
    #1;
    n_checks++;
    if (dbg_state !== 3'd0 || rb !== 1'b1) begin
      n_fail++; $display("FAIL idle_ignore: state %0d rb %b want 0/1", dbg_state, rb);
    end
    @(negedge clk);
    ren = 1'b0; io_en = 1'b1; v = 8'($urandom); io_drv = v;
    #1;
    n_checks++;
    if (F_IO !== v) begin n_fail++; $display("FAIL idle_ren_no_drive: got %h want %h", F_IO, v); end
    idle_bus();
  endtask

  task automatic test_preload();
    logic [7:0] q[$];
    int cyc;
    int rows[3] = '{5, 3, 256};
    foreach (rows[p]) begin
      q.delete();
      for (int i = 0; i < PAGE; i++) q.push_back(rows[p] == 5 ? 8'(i) : 8'($urandom));
      program_seq(rows[p], 0, q, cyc);
      n_checks++;
      if (cyc != T_PROG) begin n_fail++; $display("FAIL preload_busy row %0d: got %0d want %0d", rows[p], cyc, T_PROG); end
    end
  endtask

  task automatic test_read_wrap();
    int cyc;
    logic [7:0] got, exp;
    read_seq(5, 0, cyc);
    n_checks++;
    if (cyc != T_R) begin n_fail++; $display("FAIL read_busy: got %0d want %0d", cyc, T_R); end
    for (int k = 0; k < PAGE + 1; k++) begin
      read_byte(got);
      exp = 8'(k % 256);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL read_wrap k=%0d: got %h want %h", k, got, exp); end
    end
    idle_bus();
  endtask

  task automatic test_read1();
    int cyc;
    logic [7:0] got, exp;
    read_seq(256, 'h110, cyc);
    n_checks++;
    if (cyc != T_R) begin n_fail++; $display("FAIL read1_busy: got %0d want %0d", cyc, T_R); end
    for (int k = 0; k < 40; k++) begin
      read_byte(got);
      exp = model_mem[256 * PAGE + 'h110 + k];
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL read1 k=%0d: got %h want %h", k, got, exp); end
    end
    idle_bus();
  endtask

  task automatic test_partial_prog();
    logic [7:0] q[$];
    logic [7:0] got, exp;
    int cyc;
    q = '{8'hA5, 8'h5A};
    program_seq(3, 0, q, cyc);
    n_checks++;
    if (cyc != T_PROG) begin n_fail++; $display("FAIL prog_busy: got %0d want %0d", cyc, T_PROG); end
    read_seq(3, 0, cyc);
    for (int k = 0; k < PAGE; k++) begin
      read_byte(got);
      exp = (k == 0) ? 8'hA5 : (k == 1) ? 8'h5A : model_mem[3 * PAGE + k];
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL partial_prog k=%0d: got %h want %h", k, got, exp); end
    end
    idle_bus();
  endtask

  task automatic test_ffh_abort();
    logic [7:0] got, exp, d0, d1;
    int cyc, lows;
    write_cyc(1'b1, 1'b0, 8'h80);
    send_addr(0, 3);
    write_cyc(1'b0, 1'b0, 8'h11);
    write_cyc(1'b1, 1'b0, 8'hFF);
    idle_bus();
    #1;
    n_checks++;
    if (rb !== 1'b1 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL ffh_prog: rb %b state %0d want 1/0", rb, dbg_state);
    end
    write_cyc(1'b1, 1'b0, 8'h10);
    idle_bus();
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      #1 if (rb !== 1'b1) lows++;
      @(negedge clk);
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL stray_confirm: busy cycles %0d want 0", lows); end
    read_seq(3, 0, cyc);
    for (int k = 0; k < 4; k++) begin
      read_byte(got);
      exp = model_mem[3 * PAGE + k];
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL ffh_page_kept k=%0d: got %h want %h", k, got, exp); end
    end
    // Reset during program busy: array already committed, ready returns next cycle.
    d0 = 8'($urandom); d1 = 8'($urandom);
    write_cyc(1'b1, 1'b0, 8'h80);
    send_addr('h20, 256);
    write_cyc(1'b0, 1'b0, d0);
    write_cyc(1'b0, 1'b0, d1);
    write_cyc(1'b1, 1'b0, 8'h10);
    idle_bus();
    model_mem[256 * PAGE + 'h20] = d0;
    model_mem[256 * PAGE + 'h21] = d1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rb !== 1'b0) begin n_fail++; $display("FAIL busy_p_low: got %b want 0", rb); end
    write_cyc(1'b1, 1'b0, 8'hFF);
    idle_bus();
    #1;
    n_checks++;
    if (rb !== 1'b1) begin n_fail++; $display("FAIL ffh_busy: got %b want 1", rb); end
    read_seq(256, 'h1F, cyc);
    for (int k = 0; k < 4; k++) begin
      read_byte(got);
      exp = model_mem[256 * PAGE + 'h1F + k];
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL commit_kept k=%0d: got %h want %h", k, got, exp); end
    end
    idle_bus();
  endtask

  task automatic test_reset_busy();
    logic [7:0] got, exp;
    int cyc;
    write_cyc(1'b1, 1'b0, 8'h00);
    send_addr(0, 5);
    idle_bus();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rb !== 1'b0) begin n_fail++; $display("FAIL busy_r_low: got %b want 0", rb); end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (rb !== 1'b1 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL async_reset: rb %b state %0d want 1/0", rb, dbg_state);
    end
    @(negedge clk) rst = 1'b1;
    read_seq(256, 'h1F0, cyc);
    n_checks++;
    if (cyc != T_R) begin n_fail++; $display("FAIL post_reset_busy: got %0d want %0d", cyc, T_R); end
    for (int k = 0; k < 32; k++) begin
      read_byte(got);
      exp = model_mem[256 * PAGE + (('h1F0 + k) % PAGE)];
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL post_reset_read k=%0d: got %h want %h", k, got, exp); end
    end
    idle_bus();
  endtask

  task automatic test_random();
    int rows[3] = '{3, 5, 256};
    logic [7:0] q[$];
    logic [7:0] got, exp;
    int r, c, n, cyc;
    for (int it = 0; it < 10; it++) begin
      r = rows[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 0) begin
        c = $urandom_range(0, 255);
        n = $urandom_range(1, 8);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(8'($urandom));
        program_seq(r, c, q, cyc);
        n_checks++;
        if (cyc != T_PROG) begin n_fail++; $display("FAIL rand_prog_busy: got %0d want %0d", cyc, T_PROG); end
      end else begin
        c = $urandom_range(0, PAGE - 1);
        n = $urandom_range(1, 24);
        read_seq(r, c, cyc);
        for (int k = 0; k < n; k++) begin
          read_byte(got);
          exp = model_mem[r * PAGE + ((c + k) % PAGE)];
          n_checks++;
          if (got !== exp) begin
            n_fail++; $display("FAIL rand_read r=%0d c=%0d: got %h want %h", r, (c + k) % PAGE, got, exp);
          end
        end
        idle_bus();
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_wrap();
    test_read1();
    test_partial_prog();
    test_ffh_abort();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
